qslave_engine: RTL and testbench

Parametrised QBUS slave-cycle engine for the QSIC. It synchronises RSYNC/RDIN/RDOUT and arbitrates among NDEV register-device address matches. It sequences the Am2908 transceiver controls (DALtx/DALbe/DALst) and TRPLY for DATI, DATO, DATOB, DATIO and interrupt-vector reads. It sits between the per-device decoders (switch register, RKV11, …) and the top-level bus pins, and replaces hand-written single-device reply logic.

---
 rtl/qslave_engine_pkg.sv | 33 +++
 rtl/qslave_engine_qsync.sv | 37 +++
 rtl/qslave_engine.sv | 183 ++++++++++++++++++
 tb/tb_qslave_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qslave_engine_pkg.sv
// ============================================================================
// Module      : qslave_engine_pkg
// Description : Shared state encodings and byte-enable constants for the
//               QBUS slave-cycle engine. QSLAVE_VEC_EN adds the vector states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qslave_engine_pkg;

  typedef enum logic [2:0] {
    QS_IDLE       = 3'd0,
    QS_RD_SETTLE  = 3'd1,
    QS_RD_REPLY   = 3'd2,
`ifdef QSLAVE_VEC_EN
    QS_VEC_SETTLE = 3'd4,
    QS_VEC_REPLY  = 3'd5,
`endif
    QS_WR_REPLY   = 3'd3
  } qs_state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LOW  = 2'b01;
  localparam logic [1:0] BE_HIGH = 2'b10;

  function automatic logic [1:0] byte_enables(input logic byte_op, input logic odd);
    if (!byte_op) return BE_WORD;
    return odd ? BE_HIGH : BE_LOW;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qslave_engine_qsync.sv
// ============================================================================
// Module      : qslave_engine_qsync
// Description : STAGES-deep synchroniser for one asynchronous bus receiver,
//               with a one-cycle pulse on the synchronised rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qslave_engine_qsync #(
  parameter int STAGES = 2
) (
  input  logic clk20,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk20) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~prev;

endmodule

`default_nettype wire

// File: rtl/qslave_engine.sv
// ============================================================================
// Module      : qslave_engine
// Description : QBUS slave-cycle engine: synchronises bus strobes, picks the
//               highest-priority matching device and sequences Am2908 controls
//               and TRPLY. Define QSLAVE_VEC_EN to enable interrupt-vector reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qslave_engine
  import qslave_engine_pkg::*;
#(
  parameter int NDEV        = 4,
  parameter int SETTLE      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk20,
  input  logic                 reset,
  input  logic                 RSYNC,
  input  logic                 RDIN,
  input  logic                 RDOUT,
  input  logic                 ZWTBT,
  input  logic [21:0]          addr_reg,
  input  logic [15:0]          RDL,
  input  logic [NDEV-1:0]      dev_match,
  input  logic [16*NDEV-1:0]   dev_rdata,
  input  logic                 vec_req,
  input  logic [15:0]          vec_data,
  output logic [15:0]          tdl,
  output logic                 rwDALtx,
  output logic                 rwDALbe,
  output logic                 rwDALst,
  output logic                 TRPLY,
  output logic [NDEV-1:0]      wr_strobe,
  output logic [1:0]           wr_be,
  output logic [15:0]          wdata,
  output logic                 busy
);

  localparam int SW = (NDEV > 1) ? $clog2(NDEV) : 1;

  logic [3:0] async_in, sync_out, rise_out;
  assign async_in = {ZWTBT, RDOUT, RDIN, RSYNC};

  for (genvar g = 0; g < 4; g++) begin : g_sync
    qslave_engine_qsync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk20 (clk20),
      .reset (reset),
      .din   (async_in[g]),
      .sync  (sync_out[g]),
      .rise  (rise_out[g])
    );
  end

  logic s_rsync, s_rdin, s_rdout, s_zwtbt, rdin_rise, rdout_rise;
  assign s_rsync    = sync_out[0];
  assign s_rdin     = sync_out[1];
  assign s_rdout    = sync_out[2];
  assign s_zwtbt    = sync_out[3];
  assign rdin_rise  = rise_out[1];
  assign rdout_rise = rise_out[2];

  // Lowest-index match wins when several decoders hit at once.
  logic [SW-1:0] sel_nx;
  always_comb begin
    sel_nx = '0;
    for (int i = NDEV - 1; i >= 0; i--)
      if (dev_match[i]) sel_nx = SW'(i);
  end

  logic any_match;
  assign any_match = |dev_match;

  qs_state_t     state;
  logic [SW-1:0] sel;
  logic [3:0]    cnt;

  always_ff @(posedge clk20) begin
    if (reset) begin
      state     <= QS_IDLE;
      sel       <= '0;
      cnt       <= '0;
      tdl       <= '0;
      rwDALtx   <= 1'b0;
      rwDALbe   <= 1'b0;
      rwDALst   <= 1'b0;
      TRPLY     <= 1'b0;
      wr_strobe <= '0;
      wr_be     <= '0;
      wdata     <= '0;
    end else begin
      wr_strobe <= '0;
      case (state)
        QS_IDLE: begin
          cnt <= '0;
          if (s_rsync && any_match && rdin_rise) begin
            sel     <= sel_nx;
            tdl     <= dev_rdata[{sel_nx, 4'b0000} +: 16];
            rwDALtx <= 1'b1;
            if (SETTLE == 0) begin
              state                      <= QS_RD_REPLY;
              {rwDALbe, rwDALst, TRPLY}  <= 3'b111;
            end else begin
              state <= QS_RD_SETTLE;
            end
          end else if (s_rsync && any_match && rdout_rise) begin
            sel       <= sel_nx;
            state     <= QS_WR_REPLY;
            TRPLY     <= 1'b1;
            wr_strobe <= NDEV'(1) << sel_nx;
            wdata     <= RDL;
            wr_be     <= byte_enables(s_zwtbt, addr_reg[0]);
          end
`ifdef QSLAVE_VEC_EN
          else if (vec_req && s_rdin && !s_rsync) begin
            tdl     <= vec_data;
            rwDALtx <= 1'b1;
            if (SETTLE == 0) begin
              state                      <= QS_VEC_REPLY;
              {rwDALbe, rwDALst, TRPLY}  <= 3'b111;
            end else begin
              state <= QS_VEC_SETTLE;
            end
          end
`endif
        end
        QS_RD_SETTLE: begin
          tdl <= dev_rdata[{sel, 4'b0000} +: 16];
          if (cnt == 4'(SETTLE)) begin
            state                     <= QS_RD_REPLY;
            {rwDALbe, rwDALst, TRPLY} <= 3'b111;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
`ifdef QSLAVE_VEC_EN
        QS_VEC_SETTLE: begin
          if (cnt == 4'(SETTLE)) begin
            state                     <= QS_VEC_REPLY;
            {rwDALbe, rwDALst, TRPLY} <= 3'b111;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        QS_VEC_REPLY: begin
          if (!s_rdin) begin
            state                              <= QS_IDLE;
            {rwDALtx, rwDALbe, rwDALst, TRPLY} <= 4'b0000;
          end
        end
`endif
        QS_RD_REPLY: begin
          if (!s_rdin) begin
            state                              <= QS_IDLE;
            {rwDALtx, rwDALbe, rwDALst, TRPLY} <= 4'b0000;
          end
        end
        QS_WR_REPLY: begin
          if (!s_rdout) begin
            state <= QS_IDLE;
            TRPLY <= 1'b0;
          end
        end
        default: begin
          state                              <= QS_IDLE;
          {rwDALtx, rwDALbe, rwDALst, TRPLY} <= 4'b0000;
        end
      endcase
    end
  end

  assign busy = (state != QS_IDLE);

  logic unused_bits;
`ifdef QSLAVE_VEC_EN
  assign unused_bits = ^{addr_reg[21:1], rise_out[0], rise_out[3]};
`else
  assign unused_bits = ^{addr_reg[21:1], rise_out[0], rise_out[3], vec_req, vec_data};
`endif

endmodule

`default_nettype wire

// File: tb/tb_qslave_engine.sv
// ============================================================================
// Module      : tb_qslave_engine
// Description : Randomised self-checking bench for qslave_engine against a
//               transaction-level model of the QBUS slave protocol.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_qslave_engine;

  localparam int NDEV        = 4;
  localparam int SETTLE      = 2;
  localparam int SYNC_STAGES = 2;
  localparam int LAT_IN      = SYNC_STAGES + 1;
  localparam int LAT_SETTLE  = (SETTLE == 0) ? 0 : SETTLE + 1;

  logic                clk20 = 1'b0;
  logic                reset;
  logic                RSYNC, RDIN, RDOUT, ZWTBT;
  logic [21:0]         addr_reg;
  logic [15:0]         RDL;
  logic [NDEV-1:0]     dev_match;
  logic [16*NDEV-1:0]  dev_rdata;
  logic                vec_req;
  logic [15:0]         vec_data;
  logic [15:0]         tdl;
  logic                rwDALtx, rwDALbe, rwDALst, TRPLY;
  logic [NDEV-1:0]     wr_strobe;
  logic [1:0]          wr_be;
  logic [15:0]         wdata;
  logic                busy;

  qslave_engine #(.NDEV(NDEV), .SETTLE(SETTLE), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk20     (clk20),
    .reset     (reset),
    .RSYNC     (RSYNC),
    .RDIN      (RDIN),
    .RDOUT     (RDOUT),
    .ZWTBT     (ZWTBT),
    .addr_reg  (addr_reg),
    .RDL       (RDL),
    .dev_match (dev_match),
    .dev_rdata (dev_rdata),
    .vec_req   (vec_req),
    .vec_data  (vec_data),
    .tdl       (tdl),
    .rwDALtx   (rwDALtx),
    .rwDALbe   (rwDALbe),
    .rwDALst   (rwDALst),
    .TRPLY     (TRPLY),
    .wr_strobe (wr_strobe),
    .wr_be     (wr_be),
    .wdata     (wdata),
    .busy      (busy)
  );

  always #25 clk20 = ~clk20;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              strobe_cnt;
  logic [NDEV-1:0] last_strobe;
  logic            saw_trply, saw_dalx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk20);
    #1;
    if (wr_strobe != '0) begin
      strobe_cnt++;
      last_strobe = wr_strobe;
    end
    if (TRPLY)   saw_trply = 1'b1;
    if (rwDALtx) saw_dalx  = 1'b1;
  endtask

  // Reference model: priority is the lowest set match bit.
  function automatic int lowest(input logic [NDEV-1:0] m);
    for (int i = 0; i < NDEV; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic logic [1:0] exp_be(input logic byt, input logic a0);
    if (!byt) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

  task automatic end_cycle();
    RSYNC = 1'b0; ZWTBT = 1'b0; dev_match = '0; RDIN = 1'b0; RDOUT = 1'b0; vec_req = 1'b0;
    repeat (4) tick();
    chk("idle_busy", busy, 0);
  endtask

  task automatic do_read(input logic [NDEV-1:0] m, input logic [16*NDEV-1:0] rd);
    int n; int s; logic [15:0] e; logic held;
    s = lowest(m);
    e = rd[16*s +: 16];
    dev_match = m; dev_rdata = rd; RSYNC = 1'b1; strobe_cnt = 0;
    repeat (3) tick();
    RDIN = 1'b1;
    n = 0; while (!rwDALtx && n < 20) begin tick(); n++; end
    chk("rd_dalx_latency", n, LAT_IN);
    chk("rd_tdl", tdl, e);
    if (SETTLE != 0) chk("rd_early_trply", TRPLY, 0);
    n = 0; while (!TRPLY && n < 20) begin tick(); n++; end
    chk("rd_trply_latency", n, LAT_SETTLE);
    chk("rd_ctl_busy", {rwDALtx, rwDALbe, rwDALst, busy}, 4'hf);
    chk("rd_tdl_reply", tdl, e);
    held = 1'b1;
    repeat ($urandom_range(1, 4)) begin tick(); held &= TRPLY; end
    chk("rd_trply_hold", held, 1);
    RDIN = 1'b0;
    n = 0; while (TRPLY && n < 20) begin tick(); n++; end
    chk("rd_trply_release", n, LAT_IN);
    chk("rd_release_ctl", {rwDALtx, rwDALbe, rwDALst}, 0);
    chk("rd_no_strobe", strobe_cnt, 0);
  endtask

  task automatic do_write(input logic [NDEV-1:0] m, input logic a0, input logic byt,
                          input logic [15:0] data);
    int n; int s; logic held; logic [NDEV-1:0] es; logic [21:0] a;
    s = lowest(m);
    es = '0; es[s] = 1'b1;
    a = 22'($urandom); a[0] = a0;
    dev_match = m; addr_reg = a; ZWTBT = byt; RDL = data; RSYNC = 1'b1;
    repeat (3) tick();
    strobe_cnt = 0;
    RDOUT = 1'b1;
    n = 0; while (!TRPLY && n < 20) begin tick(); n++; end
    chk("wr_trply_latency", n, LAT_IN);
    chk("wr_strobe", wr_strobe, es);
    chk("wr_be", wr_be, exp_be(byt, a0));
    chk("wr_wdata", wdata, data);
    held = 1'b1;
    repeat ($urandom_range(1, 4)) begin tick(); held &= TRPLY; end
    chk("wr_trply_hold", held, 1);
    RDOUT = 1'b0;
    n = 0; while (TRPLY && n < 20) begin tick(); n++; end
    chk("wr_trply_release", n, LAT_IN);
    chk("wr_strobe_count", strobe_cnt, 1);
  endtask

  task automatic do_nxm(input int kind);
    saw_trply = 1'b0; saw_dalx = 1'b0; strobe_cnt = 0;
    RSYNC     = (kind != 2);
    dev_match = (kind == 2) ? NDEV'($urandom_range(1, 15)) : '0;
    repeat (3) tick();
    if ((kind == 1) || ($urandom_range(0, 1) == 1)) RDOUT = 1'b1; else RDIN = 1'b1;
    repeat (10) tick();
    chk("nxm_no_trply", saw_trply, 0);
    chk("nxm_no_dalx", saw_dalx, 0);
    chk("nxm_no_strobe", strobe_cnt, 0);
  endtask

  task automatic do_vec(input logic [15:0] v);
    int n;
    RSYNC = 1'b0; dev_match = NDEV'($urandom); vec_req = 1'b1; vec_data = v;
    saw_trply = 1'b0;
    repeat (3) tick();
    RDIN = 1'b1;
`ifdef QSLAVE_VEC_EN
    n = 0; while (!rwDALtx && n < 20) begin tick(); n++; end
    chk("vec_dalx_latency", n, LAT_IN);
    chk("vec_tdl", tdl, v);
    n = 0; while (!TRPLY && n < 20) begin tick(); n++; end
    chk("vec_trply_latency", n, LAT_SETTLE);
    chk("vec_ctl", {rwDALtx, rwDALbe, rwDALst}, 3'b111);
    RDIN = 1'b0;
    n = 0; while (TRPLY && n < 20) begin tick(); n++; end
    chk("vec_trply_release", n, LAT_IN);
`else
    n = 0;
    repeat (12) tick();
    chk("vec_disabled_no_trply", saw_trply, 0);
    RDIN = 1'b0;
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16*NDEV-1:0] rd;
    logic [NDEV-1:0]    m;
    int                 kind;
    int                 n;

    reset = 1'b1; RSYNC = 1'b0; RDIN = 1'b0; RDOUT = 1'b0; ZWTBT = 1'b0;
    addr_reg = '0; RDL = '0; dev_match = '0; dev_rdata = '0; vec_req = 1'b0; vec_data = '0;
    strobe_cnt = 0; last_strobe = '0; saw_trply = 1'b0; saw_dalx = 1'b0;
    repeat (3) tick();
    chk("reset_ctl", {TRPLY, rwDALtx, rwDALbe, rwDALst, busy}, 0);
    chk("reset_data", {tdl, wdata}, 0);
    chk("reset_wr", {wr_strobe, wr_be}, 0);
    reset = 1'b0;
    repeat (2) tick();

    rd = {$urandom, $urandom}; rd[16*2 +: 16] = 16'o123456;
    do_read(4'b0100, rd);
    end_cycle();

    do_write(4'b0001, 1'b1, 1'b1, 16'o000377);
    chk("datob_target", last_strobe, 4'b0001);
    end_cycle();

    rd = {$urandom, $urandom};
    do_read(4'b1010, rd);
    end_cycle();

    // DATIO: write follows the read inside one RSYNC
    rd = {$urandom, $urandom};
    do_read(4'b0110, rd);
    tick();
    do_write(4'b1100, 1'b0, 1'b0, 16'($urandom));
    end_cycle();

    do_vec(16'o000220);
    end_cycle();

    // Reset just before the write strobe edge
    dev_match = 4'b0010; ZWTBT = 1'b0; RDL = 16'($urandom); RSYNC = 1'b1;
    repeat (3) tick();
    strobe_cnt = 0;
    RDOUT = 1'b1;
    repeat (LAT_IN - 1) tick();
    reset = 1'b1; RDOUT = 1'b0; RSYNC = 1'b0; dev_match = '0;
    tick();
    chk("rst_wr_ctl", {TRPLY, rwDALtx, rwDALbe, rwDALst, busy}, 0);
    chk("rst_wr_outs", {wr_strobe, wr_be, wdata}, 0);
    reset = 1'b0;
    repeat (6) tick();
    chk("rst_wr_no_strobe", strobe_cnt, 0);

    // Reset during a read reply
    dev_match = 4'b1000; dev_rdata = {$urandom, $urandom}; RSYNC = 1'b1;
    repeat (3) tick();
    RDIN = 1'b1;
    n = 0; while (!TRPLY && n < 20) begin tick(); n++; end
    reset = 1'b1; RDIN = 1'b0; RSYNC = 1'b0; dev_match = '0;
    tick();
    chk("rst_rd_ctl", {TRPLY, rwDALtx, rwDALbe, rwDALst, busy}, 0);
    chk("rst_rd_tdl", tdl, 0);
    reset = 1'b0;
    repeat (4) tick();

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 4);
      m    = NDEV'($urandom_range(1, 15));
      rd   = {$urandom, $urandom};
      case (kind)
        0: do_read(m, rd);
        1: do_write(m, 1'($urandom), 1'($urandom), 16'($urandom));
        2: begin
          do_read(m, rd);
          tick();
          do_write(NDEV'($urandom_range(1, 15)), 1'($urandom), 1'($urandom), 16'($urandom));
        end
        3: do_nxm($urandom_range(0, 2));
        default: do_vec(16'($urandom));
      endcase
      end_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
